instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 23 ++
 rtl/fetch_skid.sv | 55 +++++
 rtl/instr_fetch.sv | 99 +++++++++
 tb/tb_instr_fetch.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared memory port constants and fetch state encodings
package instr_fetch_pkg;

   localparam logic       MM_ENB_R = 1'b0;
   localparam logic       MM_ENB_W = 1'b1;
   localparam logic [1:0] MW_Byte  = 2'd0;
   localparam logic [1:0] MW_Half  = 2'd1;
   localparam logic [1:0] MW_Word  = 2'd2;

   localparam int PC_W   = 12;
   localparam int SKID_W = PC_W + 32;

   typedef enum logic {
      FS_FETCH = 1'b0,
      FS_HALT  = 1'b1
   } fetch_state_e;

   // Word step through the 4 KiB window, wrapping 0xFFC -> 0x000.
   function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
      return pc + 12'd4;
   endfunction

endpackage

// File: rtl/fetch_skid.sv
// rtl/fetch_skid.sv - two-entry FIFO between memory capture and the instruction consumer
module fetch_skid #(
   parameter int WIDTH = 44
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             head_valid,
   output logic [WIDTH-1:0] head_data,
   output logic [1:0]       count
);

   logic [WIDTH-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
   logic [1:0]       cnt_q, cnt_d;

   always_comb begin
      ent0_d = ent0_q;
      ent1_d = ent1_q;
      cnt_d  = cnt_q;
      if (flush) begin
         cnt_d = 2'd0;
      end else begin
         if (pop && cnt_q != 2'd0) begin
            ent0_d = ent1_q;
            cnt_d  = cnt_q - 2'd1;
         end
         // after any pop, the free slot sits at index cnt_d
         if (push && cnt_d != 2'd2) begin
            if (cnt_d == 2'd0) ent0_d = push_data;
            else               ent1_d = push_data;
            cnt_d = cnt_d + 2'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ent0_q <= '0;
         ent1_q <= '0;
         cnt_q  <= 2'd0;
      end else begin
         ent0_q <= ent0_d;
         ent1_q <= ent1_d;
         cnt_q  <= cnt_d;
      end
   end

   assign head_valid = (cnt_q != 2'd0);
   assign head_data  = ent0_q;
   assign count      = cnt_q;

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - prefetching instruction fetch unit on memory port B with redirect and halt
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0800,
   parameter logic [31:0] HALT_WORD = 32'h0000_FFFF
) (
   input  logic        clk,
   input  logic        rst,
   output logic        mem_en_wr,
   output logic [1:0]  mem_size,
   output logic [31:0] mem_abus,
   output logic [31:0] mem_dbusw,
   input  logic [31:0] mem_dbusr,
   input  logic        redir_valid,
   input  logic [31:0] redir_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic        halted
);

   fetch_state_e      state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d, issue_pc_q, issue_pc_d;
   logic              inflight_q, inflight_d;
   logic              push, flush, transfer, halt_hit;
   logic [2:0]        occupancy;
   logic [1:0]        skid_count;
   logic [SKID_W-1:0] skid_head;
   logic              unused_redir;

   assign unused_redir = ^{redir_pc[31:PC_W], redir_pc[1:0]};
   assign transfer     = out_valid && out_ready;
   assign halt_hit     = inflight_q && (mem_dbusr == HALT_WORD);
   assign occupancy    = {1'b0, skid_count} + {2'b0, inflight_q} - {2'b0, transfer};

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      issue_pc_d = issue_pc_q;
      inflight_d = 1'b0;
      push       = 1'b0;
      flush      = 1'b0;
      if (redir_valid) begin
         flush   = 1'b1;
         pc_d    = {redir_pc[PC_W-1:2], 2'b00};
         state_d = FS_FETCH;
      end else if (halt_hit) begin
         // park the address on the HALT word so nothing past it is ever presented
         state_d = FS_HALT;
         pc_d    = issue_pc_q;
      end else begin
         push = inflight_q;
         if (state_q == FS_FETCH && occupancy < 3'd2) begin
            inflight_d = 1'b1;
            issue_pc_d = pc_q;
            pc_d       = pc_next(pc_q);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= FS_FETCH;
         pc_q       <= RESET_PC[PC_W-1:0];
         issue_pc_q <= '0;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         issue_pc_q <= issue_pc_d;
         inflight_q <= inflight_d;
      end
   end

   fetch_skid #(
      .WIDTH(SKID_W)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .push      (push),
      .push_data ({issue_pc_q, mem_dbusr}),
      .pop       (transfer),
      .head_valid(out_valid),
      .head_data (skid_head),
      .count     (skid_count)
   );

   assign out_instr = skid_head[31:0];
   assign out_pc    = {{(32-PC_W){1'b0}}, skid_head[SKID_W-1:32]};
   assign halted    = (state_q == FS_HALT) && (skid_count == 2'd0);
   assign mem_abus  = {{(32-PC_W){1'b0}}, pc_q};
   assign mem_en_wr = MM_ENB_R;
   assign mem_size  = MW_Word;
   assign mem_dbusw = 32'h0;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - randomized self-checking bench for instr_fetch against a program-stream model
module tb_instr_fetch;

   localparam logic [31:0] HALT = 32'h0000_FFFF;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        mem_en_wr;
   logic [1:0]  mem_size;
   logic [31:0] mem_abus, mem_dbusw, mem_dbusr;
   logic        redir_valid = 1'b0;
   logic [31:0] redir_pc = 32'h0;
   logic        out_valid, out_ready = 1'b0;
   logic [31:0] out_instr, out_pc;
   logic        halted;

   int tests_run = 0;
   int tests_failed = 0;

   logic [31:0] mem [0:1023];
   logic [31:0] got_pc[$], got_instr[$], exp_pc[$], exp_instr[$];

   always #5 clk = ~clk;

   instr_fetch dut (
      .clk(clk), .rst(rst), .mem_en_wr(mem_en_wr), .mem_size(mem_size),
      .mem_abus(mem_abus), .mem_dbusw(mem_dbusw), .mem_dbusr(mem_dbusr),
      .redir_valid(redir_valid), .redir_pc(redir_pc), .out_valid(out_valid),
      .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc), .halted(halted)
   );

   // Mem4K port B: synchronous read, data one cycle after its address
   always @(posedge clk) mem_dbusr <= mem[mem_abus[11:2]];

   task automatic port_a_write(input logic [11:0] addr, input logic [31:0] data);
      mem[addr[11:2]] = data;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 1024; i++) mem[i] = HALT;
   endtask

   function automatic logic [31:0] rand_word();
      logic [31:0] w;
      w = $urandom();
      if (w == HALT) w = 32'h1;
      return w;
   endfunction

   // Reference: words from start, stepping +4 mod 4096, up to (not including) the first HALT word.
   task automatic build_expected(input logic [11:0] start);
      logic [11:0] p;
      p = start;
      exp_pc.delete();
      exp_instr.delete();
      for (int n = 0; n < 1024; n++) begin
         if (mem[p[11:2]] == HALT) break;
         exp_pc.push_back({20'b0, p});
         exp_instr.push_back(mem[p[11:2]]);
         p = p + 12'd4;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      redir_valid = 1'b0;
      out_ready = 1'b0;
      got_pc.delete();
      got_instr.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic collect(input int ready_pct, input int budget, output bit saw_halt);
      saw_halt = 1'b0;
      for (int c = 0; c < budget; c++) begin
         if (halted) begin
            saw_halt = 1'b1;
            break;
         end
         out_ready = ($urandom_range(99) < ready_pct);
         if (out_valid && out_ready) begin
            got_pc.push_back(out_pc);
            got_instr.push_back(out_instr);
         end
         @(negedge clk);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      clear_mem();
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      tests_run++;
      if ({out_valid, halted} !== 2'b00) begin
         tests_failed++;
         $display("FAIL reset_flags: valid/halted %b, expected 00", {out_valid, halted});
      end
      tests_run++;
      if (out_instr !== 32'h0 || out_pc !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_out: instr %h pc %h, expected 0 0", out_instr, out_pc);
      end
      tests_run++;
      if (mem_abus !== 32'h800) begin
         tests_failed++;
         $display("FAIL reset_abus: got %h, expected 00000800", mem_abus);
      end
      tests_run++;
      if (mem_en_wr !== 1'b0 || mem_size !== 2'd2 || mem_dbusw !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_memctl: en_wr %b size %0d dbusw %h, expected 0 2 0", mem_en_wr, mem_size, mem_dbusw);
      end
   endtask

   task automatic test_halt_program();
      int cyc_of[$];
      clear_mem();
      port_a_write(12'h800, 32'h0010_0093);
      port_a_write(12'h804, 32'h0020_0113);
      port_a_write(12'h808, HALT);
      do_reset();
      out_ready = 1'b1;
      for (int c = 0; c < 30 && !halted; c++) begin
         if (out_valid) begin
            got_pc.push_back(out_pc);
            got_instr.push_back(out_instr);
            cyc_of.push_back(c);
         end
         @(negedge clk);
      end
      tests_run++;
      if (got_pc.size() != 2) begin
         tests_failed++;
         $display("FAIL halt_count: got %0d transfers, expected 2", got_pc.size());
      end else begin
         tests_run++;
         if (cyc_of[0] != 2 || cyc_of[1] != 3) begin
            tests_failed++;
            $display("FAIL halt_timing: transfers at cycles %0d,%0d, expected 2,3", cyc_of[0], cyc_of[1]);
         end
         tests_run++;
         if (got_pc[0] !== 32'h800 || got_pc[1] !== 32'h804 ||
             got_instr[0] !== 32'h0010_0093 || got_instr[1] !== 32'h0020_0113) begin
            tests_failed++;
            $display("FAIL halt_data: got %h@%h %h@%h, expected 00100093@800 00200113@804",
                     got_instr[0], got_pc[0], got_instr[1], got_pc[1]);
         end
      end
      for (int c = 0; c < 8; c++) begin
         tests_run++;
         if (halted !== 1'b1 || mem_abus > 32'h808) begin
            tests_failed++;
            $display("FAIL halt_hold: halted %b abus %h, expected 1 and <= 808", halted, mem_abus);
         end
         @(negedge clk);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      bit saw;
      clear_mem();
      for (int i = 0; i < 8; i++) port_a_write(12'h800 + 12'(4 * i), rand_word());
      build_expected(12'h800);
      do_reset();
      for (int c = 0; c < 10 && !out_valid; c++) @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL bp_first_valid: out_valid %b, expected 1 within 10 cycles", out_valid);
      end
      for (int c = 0; c < 5; c++) begin
         tests_run++;
         if (out_valid !== 1'b1 || out_pc !== 32'h800 || mem_abus !== 32'h808) begin
            tests_failed++;
            $display("FAIL bp_hold%0d: valid %b pc %h abus %h, expected 1 800 808", c, out_valid, out_pc, mem_abus);
         end
         @(negedge clk);
      end
      collect(100, 100, saw);
      tests_run++;
      if (!saw || got_pc.size() != exp_pc.size()) begin
         tests_failed++;
         $display("FAIL bp_count: halted %b, %0d transfers, expected 1, %0d", saw, got_pc.size(), exp_pc.size());
      end
      for (int i = 0; i < got_pc.size() && i < exp_pc.size(); i++) begin
         tests_run++;
         if (got_pc[i] !== exp_pc[i] || got_instr[i] !== exp_instr[i]) begin
            tests_failed++;
            $display("FAIL bp_entry%0d: got %h@%h, expected %h@%h", i, got_instr[i], got_pc[i], exp_instr[i], exp_pc[i]);
         end
      end
   endtask

   task automatic test_random_ready();
      bit saw;
      int len;
      for (int it = 0; it < 3; it++) begin
         clear_mem();
         len = $urandom_range(12, 3);
         for (int i = 0; i < len; i++) port_a_write(12'h800 + 12'(4 * i), rand_word());
         build_expected(12'h800);
         do_reset();
         collect(50, 400, saw);
         tests_run++;
         if (!saw || got_pc.size() != len) begin
            tests_failed++;
            $display("FAIL rand%0d_count: halted %b, %0d transfers, expected 1, %0d", it, saw, got_pc.size(), len);
         end
         for (int i = 0; i < got_pc.size() && i < exp_pc.size(); i++) begin
            tests_run++;
            if (got_pc[i] !== exp_pc[i] || got_instr[i] !== exp_instr[i]) begin
               tests_failed++;
               $display("FAIL rand%0d_entry%0d: got %h@%h, expected %h@%h", it, i, got_instr[i], got_pc[i], exp_instr[i], exp_pc[i]);
            end
         end
      end
   endtask

   task automatic test_redirect();
      bit saw;
      int n;
      clear_mem();
      for (int i = 0; i < 16; i++) port_a_write(12'h800 + 12'(4 * i), rand_word());
      for (int i = 0; i < 6; i++)  port_a_write(12'h900 + 12'(4 * i), rand_word());
      build_expected(12'h800);
      do_reset();
      out_ready = 1'b1;
      n = 0;
      for (int c = 0; c < 20 && n < 3; c++) begin
         if (out_valid) begin
            got_pc.push_back(out_pc);
            got_instr.push_back(out_instr);
            n++;
         end
         if (n == 3) begin
            redir_valid = 1'b1;
            redir_pc = 32'h0000_0903;
         end
         @(negedge clk);
      end
      redir_valid = 1'b0;
      tests_run++;
      if (n != 3) begin
         tests_failed++;
         $display("FAIL redir_pre_count: %0d transfers before redirect, expected 3", n);
      end
      for (int i = 0; i < got_pc.size(); i++) begin
         tests_run++;
         if (got_pc[i] !== exp_pc[i] || got_instr[i] !== exp_instr[i]) begin
            tests_failed++;
            $display("FAIL redir_pre%0d: got %h@%h, expected %h@%h", i, got_instr[i], got_pc[i], exp_instr[i], exp_pc[i]);
         end
      end
      for (int c = 0; c < 2; c++) begin
         tests_run++;
         if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL redir_gap%0d: out_valid %b, expected 0", c, out_valid);
         end
         @(negedge clk);
      end
      tests_run++;
      if (out_valid !== 1'b1 || out_pc !== 32'h900) begin
         tests_failed++;
         $display("FAIL redir_target: valid %b pc %h, expected 1 00000900", out_valid, out_pc);
      end
      got_pc.delete();
      got_instr.delete();
      build_expected(12'h900);
      collect(100, 100, saw);
      tests_run++;
      if (!saw || got_pc.size() != 6) begin
         tests_failed++;
         $display("FAIL redir_post_count: halted %b, %0d transfers, expected 1, 6", saw, got_pc.size());
      end
      for (int i = 0; i < got_pc.size() && i < exp_pc.size(); i++) begin
         tests_run++;
         if (got_pc[i] !== exp_pc[i] || got_instr[i] !== exp_instr[i]) begin
            tests_failed++;
            $display("FAIL redir_post%0d: got %h@%h, expected %h@%h", i, got_instr[i], got_pc[i], exp_instr[i], exp_pc[i]);
         end
      end
   endtask

   task automatic test_redirect_halted();
      bit saw;
      clear_mem();
      for (int i = 0; i < 3; i++) port_a_write(12'h800 + 12'(4 * i), rand_word());
      build_expected(12'h800);
      do_reset();
      collect(100, 50, saw);
      tests_run++;
      if (!saw) begin
         tests_failed++;
         $display("FAIL rh_halt: halted %b, expected 1", halted);
      end
      redir_valid = 1'b1;
      redir_pc = 32'h0000_0800;
      @(negedge clk);
      redir_valid = 1'b0;
      tests_run++;
      if (halted !== 1'b0) begin
         tests_failed++;
         $display("FAIL rh_drop: halted %b, expected 0", halted);
      end
      got_pc.delete();
      got_instr.delete();
      collect(100, 50, saw);
      tests_run++;
      if (!saw || got_pc.size() != exp_pc.size()) begin
         tests_failed++;
         $display("FAIL rh_count: halted %b, %0d transfers, expected 1, %0d", saw, got_pc.size(), exp_pc.size());
      end
      for (int i = 0; i < got_pc.size() && i < exp_pc.size(); i++) begin
         tests_run++;
         if (got_pc[i] !== exp_pc[i] || got_instr[i] !== exp_instr[i]) begin
            tests_failed++;
            $display("FAIL rh_entry%0d: got %h@%h, expected %h@%h", i, got_instr[i], got_pc[i], exp_instr[i], exp_pc[i]);
         end
      end
   endtask

   task automatic test_wrap();
      bit saw;
      logic [31:0] want_pc [3];
      want_pc = '{32'hFF8, 32'hFFC, 32'h000};
      clear_mem();
      port_a_write(12'hFF8, rand_word());
      port_a_write(12'hFFC, rand_word());
      port_a_write(12'h000, rand_word());
      build_expected(12'hFF8);
      do_reset();
      collect(100, 50, saw);
      tests_run++;
      if (!saw || got_pc.size() != 0) begin
         tests_failed++;
         $display("FAIL wrap_halt_at_reset: halted %b, %0d transfers, expected 1, 0", saw, got_pc.size());
      end
      redir_valid = 1'b1;
      redir_pc = 32'hABCD_EFFB;
      @(negedge clk);
      redir_valid = 1'b0;
      collect(100, 50, saw);
      tests_run++;
      if (!saw || got_pc.size() != 3) begin
         tests_failed++;
         $display("FAIL wrap_count: halted %b, %0d transfers, expected 1, 3", saw, got_pc.size());
      end
      for (int i = 0; i < got_pc.size() && i < 3; i++) begin
         tests_run++;
         if (got_pc[i] !== want_pc[i] || got_instr[i] !== exp_instr[i]) begin
            tests_failed++;
            $display("FAIL wrap_entry%0d: got %h@%h, expected %h@%h", i, got_instr[i], got_pc[i], exp_instr[i], want_pc[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      bit saw;
      clear_mem();
      for (int i = 0; i < 8; i++) port_a_write(12'h800 + 12'(4 * i), rand_word());
      build_expected(12'h800);
      do_reset();
      for (int c = 0; c < 4; c++) @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b1 || out_pc !== 32'h800) begin
         tests_failed++;
         $display("FAIL rm_buffered: valid %b pc %h, expected 1 00000800", out_valid, out_pc);
      end
      rst = 1'b0;
      #1;
      tests_run++;
      if (out_valid !== 1'b0 || mem_abus !== 32'h800 || halted !== 1'b0) begin
         tests_failed++;
         $display("FAIL rm_async: valid %b abus %h halted %b, expected 0 00000800 0", out_valid, mem_abus, halted);
      end
      @(negedge clk);
      rst = 1'b1;
      collect(100, 100, saw);
      tests_run++;
      if (!saw || got_pc.size() != exp_pc.size()) begin
         tests_failed++;
         $display("FAIL rm_count: halted %b, %0d transfers, expected 1, %0d", saw, got_pc.size(), exp_pc.size());
      end
      for (int i = 0; i < got_pc.size() && i < exp_pc.size(); i++) begin
         tests_run++;
         if (got_pc[i] !== exp_pc[i] || got_instr[i] !== exp_instr[i]) begin
            tests_failed++;
            $display("FAIL rm_entry%0d: got %h@%h, expected %h@%h", i, got_instr[i], got_pc[i], exp_instr[i], exp_pc[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_halt_program();
      test_backpressure();
      test_random_ready();
      test_redirect();
      test_redirect_halted();
      test_wrap();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

endmodule
